// File: rtl/enemy_spawn_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// enemy_spawn_ctrl_pkg
// Shared game definitions for the enemy lifecycle logic.
//   enemy_state_t               3-bit lifecycle state encoding (also shown on state_out)
//   DEFAULT_SPAWN_DELAY_FRAMES  frame ticks spent waiting before each spawn
//   DEFAULT_DEATH_ANIM_FRAMES   frame ticks spent playing the death animation
//   DEFAULT_KILL_W              default kill counter width
//   timer_width()               frame-timer width able to hold the longer delay
// ---------------------------------------------------------------------------
package enemy_spawn_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SPAWN_WAIT = 3'd1,
        ST_SPAWN      = 3'd2,
        ST_ALIVE      = 3'd3,
        ST_DYING      = 3'd4
    } enemy_state_t;

    localparam int DEFAULT_SPAWN_DELAY_FRAMES = 60;
    localparam int DEFAULT_DEATH_ANIM_FRAMES  = 30;
    localparam int DEFAULT_KILL_W             = 8;

    // The timer is loaded with (frames - 1), so $clog2 of the larger frame
    // count is enough bits; a floor of 1 keeps the vector legal when both
    // delays are a single frame.
    function automatic int timer_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// ---------------------------------------------------------------------------
// frame_tick_gen
// Turns the level frame strobe into a single-Clk-cycle tick on each rising
// edge. The tick is registered and appears two Clk edges after frame_clk
// first goes high.
// Ports:
//   Clk        in   system clock
//   Reset      in   asynchronous, active-low reset
//   frame_clk  in   ~60 Hz frame strobe, level, Clk-synchronous
//   tick       out  one-cycle pulse per frame_clk rising edge
// ---------------------------------------------------------------------------
module frame_tick_gen
    import enemy_spawn_ctrl_pkg::*;
(
    input  logic Clk,
    input  logic Reset,
    input  logic frame_clk,
    output logic tick
);

    logic frame_d1;
    logic frame_d2;

    // Two-stage history of the strobe; the tick is registered from the
    // delayed pair so it is glitch-free and exactly one cycle wide.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            frame_d1 <= 1'b0;
            frame_d2 <= 1'b0;
            tick     <= 1'b0;
        end else begin
            frame_d1 <= frame_clk;
            frame_d2 <= frame_d1;
            tick     <= frame_d1 & ~frame_d2;
        end
    end

endmodule

// File: rtl/enemy_spawn_ctrl.sv
// ---------------------------------------------------------------------------
// enemy_spawn_ctrl
// Lifecycle sequencer for one enemy: spawns it by resetting the health
// block, gates weapon hits while it is alive, watches the dead flag, times
// the death animation and respawn delay in frame ticks, and counts kills.
// Ports:
//   Clk            in   system clock
//   Reset          in   asynchronous, active-low reset
//   frame_clk      in   frame strobe (level)
//   start          in   begin play (IDLE only)
//   player_dead    in   abort to IDLE from any state
//   hit_in         in   raw weapon/enemy collision
//   enemy_dead     in   dead flag from the health block
//   health_rst     out  synchronous reset to the health block
//   enemy_hit_en   out  gated hit to the health block (combinational)
//   enemy_visible  out  draw enemy sprite
//   enemy_dying    out  draw death animation
//   kill_count     out  saturating kill counter
//   state_out      out  current state encoding
// ---------------------------------------------------------------------------
module enemy_spawn_ctrl
    import enemy_spawn_ctrl_pkg::*;
#(
    parameter int SPAWN_DELAY_FRAMES = DEFAULT_SPAWN_DELAY_FRAMES,
    parameter int DEATH_ANIM_FRAMES  = DEFAULT_DEATH_ANIM_FRAMES,
    parameter int KILL_W             = DEFAULT_KILL_W
)(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              frame_clk,
    input  logic              start,
    input  logic              player_dead,
    input  logic              hit_in,
    input  logic              enemy_dead,
    output logic              health_rst,
    output logic              enemy_hit_en,
    output logic              enemy_visible,
    output logic              enemy_dying,
    output logic [KILL_W-1:0] kill_count,
    output logic [2:0]        state_out
);

    localparam int TIMER_W = timer_width(SPAWN_DELAY_FRAMES, DEATH_ANIM_FRAMES);
    localparam logic [TIMER_W-1:0] SPAWN_LOAD = TIMER_W'(SPAWN_DELAY_FRAMES - 1);
    localparam logic [TIMER_W-1:0] DEATH_LOAD = TIMER_W'(DEATH_ANIM_FRAMES - 1);
    localparam logic [KILL_W-1:0]  KILL_MAX   = '1;

    enemy_state_t      state;
    enemy_state_t      state_nxt;
    logic [TIMER_W-1:0] timer;
    logic [TIMER_W-1:0] timer_nxt;
    logic [KILL_W-1:0]  kill_nxt;
    logic               alive_settled;
    logic               settled_nxt;
    logic               health_rst_nxt;
    logic               visible_nxt;
    logic               dying_nxt;
    logic               frame_tick;

    frame_tick_gen u_frame_tick_gen (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .tick      (frame_tick)
    );

    // Next-state, timer and kill-counter logic. Timers only move on frame
    // ticks and reaching zero on a tick ends the wait, so a load of N-1
    // gives exactly N ticks. alive_settled masks enemy_dead during the first
    // ALIVE cycle while the health block recovers from its spawn reset.
    // The player_dead override is applied last so it beats every other
    // transition, including a kill in the same cycle.
    always_comb begin
        state_nxt   = state;
        timer_nxt   = timer;
        kill_nxt    = kill_count;
        settled_nxt = 1'b0;

        case (state)
            ST_IDLE: begin
                timer_nxt = '0;
                if (start && !player_dead) begin
                    state_nxt = ST_SPAWN_WAIT;
                    timer_nxt = SPAWN_LOAD;
                end
            end
            ST_SPAWN_WAIT: begin
                if (frame_tick) begin
                    if (timer == '0) begin
                        state_nxt = ST_SPAWN;
                    end else begin
                        timer_nxt = timer - 1'b1;
                    end
                end
            end
            ST_SPAWN: begin
                state_nxt = ST_ALIVE;
            end
            ST_ALIVE: begin
                settled_nxt = 1'b1;
                if (alive_settled && enemy_dead) begin
                    state_nxt = ST_DYING;
                    timer_nxt = DEATH_LOAD;
                    if (kill_count != KILL_MAX) begin
                        kill_nxt = kill_count + 1'b1;
                    end
                end
            end
            ST_DYING: begin
                if (frame_tick) begin
                    if (timer == '0) begin
                        state_nxt = ST_SPAWN_WAIT;
                        timer_nxt = SPAWN_LOAD;
                    end else begin
                        timer_nxt = timer - 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                timer_nxt = '0;
            end
        endcase

        if (player_dead && state != ST_IDLE) begin
            state_nxt   = ST_IDLE;
            timer_nxt   = '0;
            kill_nxt    = kill_count;
            settled_nxt = 1'b0;
        end

        health_rst_nxt = (state_nxt == ST_IDLE) || (state_nxt == ST_SPAWN);
        visible_nxt    = (state_nxt == ST_ALIVE);
        dying_nxt      = (state_nxt == ST_DYING);
    end

    // State, timer, counter and registered sprite/health outputs. The
    // outputs are decoded from the next state so they line up with state.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state         <= ST_IDLE;
            timer         <= '0;
            kill_count    <= '0;
            alive_settled <= 1'b0;
            health_rst    <= 1'b1;
            enemy_visible <= 1'b0;
            enemy_dying   <= 1'b0;
        end else begin
            state         <= state_nxt;
            timer         <= timer_nxt;
            kill_count    <= kill_nxt;
            alive_settled <= settled_nxt;
            health_rst    <= health_rst_nxt;
            enemy_visible <= visible_nxt;
            enemy_dying   <= dying_nxt;
        end
    end

    // Hits pass straight through while alive so the health block sees them
    // in the same cycle as the collision.
    assign enemy_hit_en = (state == ST_ALIVE) && hit_in;
    assign state_out    = state;

endmodule

// File: tb/tb_enemy_spawn_ctrl.sv
// ---------------------------------------------------------------------------
// tb_enemy_spawn_ctrl
// Bench for enemy_spawn_ctrl. One instance uses the default frame counts for
// the long timing sequences; a second, with one-frame delays and a 2-bit kill
// counter, runs a table of per-cycle vectors including kill saturation.
// ---------------------------------------------------------------------------
module tb_enemy_spawn_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // default-parameter instance
    logic       rst_n, frame_clk, start, player_dead, hit_in, enemy_dead;
    logic       health_rst, enemy_hit_en, enemy_visible, enemy_dying;
    logic [7:0] kill_count;
    logic [2:0] state_out;

    // one-frame-delay, KILL_W=2 instance
    logic       rst2_n, frame_clk2, start2, player_dead2, hit_in2, enemy_dead2;
    logic       health_rst2, enemy_hit_en2, enemy_visible2, enemy_dying2;
    logic [1:0] kill_count2;
    logic [2:0] state_out2;

    int tests_run    = 0;
    int tests_failed = 0;

    enemy_spawn_ctrl u_dut (
        .Clk           (clk),
        .Reset         (rst_n),
        .frame_clk     (frame_clk),
        .start         (start),
        .player_dead   (player_dead),
        .hit_in        (hit_in),
        .enemy_dead    (enemy_dead),
        .health_rst    (health_rst),
        .enemy_hit_en  (enemy_hit_en),
        .enemy_visible (enemy_visible),
        .enemy_dying   (enemy_dying),
        .kill_count    (kill_count),
        .state_out     (state_out)
    );

    enemy_spawn_ctrl #(
        .SPAWN_DELAY_FRAMES (1),
        .DEATH_ANIM_FRAMES  (1),
        .KILL_W             (2)
    ) u_dut_small (
        .Clk           (clk),
        .Reset         (rst2_n),
        .frame_clk     (frame_clk2),
        .start         (start2),
        .player_dead   (player_dead2),
        .hit_in        (hit_in2),
        .enemy_dead    (enemy_dead2),
        .health_rst    (health_rst2),
        .enemy_hit_en  (enemy_hit_en2),
        .enemy_visible (enemy_visible2),
        .enemy_dying   (enemy_dying2),
        .kill_count    (kill_count2),
        .state_out     (state_out2)
    );

    typedef struct packed {
        logic       fc;
        logic       st;
        logic       pd;
        logic       hit;
        logic       dead;
        logic [2:0] e_state;
        logic       e_hrst;
        logic       e_hen;
        logic       e_vis;
        logic       e_dying;
        logic [1:0] e_kills;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   vec_idx = 0;

    function automatic vec_t mk(input logic fc, input logic st, input logic pd,
                                input logic hit, input logic dead,
                                input logic [2:0] s, input logic hr, input logic he,
                                input logic vi, input logic dy, input logic [1:0] k);
        vec_t v;
        v.fc = fc; v.st = st; v.pd = pd; v.hit = hit; v.dead = dead;
        v.e_state = s; v.e_hrst = hr; v.e_hen = he; v.e_vis = vi;
        v.e_dying = dy; v.e_kills = k;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkValue(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Pops the oldest expected record and compares every output of the
    // small instance against it.
    task automatic checkOutput();
        vec_t e;
        logic [8:0] act, exp;
        e = exp_q.pop_front();
        act = {state_out2, health_rst2, enemy_hit_en2, enemy_visible2, enemy_dying2, kill_count2};
        exp = {e.e_state, e.e_hrst, e.e_hen, e.e_vis, e.e_dying, e.e_kills};
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL vec%0d: got state=%0d hrst=%b hen=%b vis=%b dying=%b kills=%0d, expected state=%0d hrst=%b hen=%b vis=%b dying=%b kills=%0d",
                     vec_idx, act[8:6], act[5], act[4], act[3], act[2], act[1:0],
                     exp[8:6], exp[5], exp[4], exp[3], exp[2], exp[1:0]);
        end
        vec_idx++;
    endtask

    task automatic applyStimulus(input vec_t v);
        frame_clk2   = v.fc;
        start2       = v.st;
        player_dead2 = v.pd;
        hit_in2      = v.hit;
        enemy_dead2  = v.dead;
        exp_q.push_back(v);
        step();
        checkOutput();
    endtask

    task automatic frameTicks(input int n);
        repeat (n) begin
            frame_clk = 1'b1;
            step();
            step();
            frame_clk = 1'b0;
            step();
            step();
        end
    endtask

    // Raises one frame pulse and waits, bounded, for the target state.
    task automatic waitForState(input logic [2:0] target, input string name, output int cycles);
        bit seen;
        seen   = 1'b0;
        cycles = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            frame_clk = (k < 2);
            step();
            cycles = k + 1;
            if (state_out == target) seen = 1'b1;
        end
        frame_clk = 1'b0;
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("[TB] FAIL %s: state %0d, expected %0d within 10 cycles", name, state_out, target);
        end
    endtask

    initial begin
        int lat;
        logic [1:0] prev_k, now_k;
        int e;

        rst_n = 1'b0; frame_clk = 0; start = 0; player_dead = 0; hit_in = 0; enemy_dead = 0;
        rst2_n = 1'b0; frame_clk2 = 0; start2 = 0; player_dead2 = 0; hit_in2 = 0; enemy_dead2 = 0;
        repeat (3) step();
        checkValue("reset state", {5'd0, state_out}, 8'd0);
        checkValue("reset health_rst", {7'd0, health_rst}, 8'd1);
        checkValue("reset outputs", {5'd0, enemy_hit_en, enemy_visible, enemy_dying}, 8'd0);
        checkValue("reset kill_count", kill_count, 8'd0);
        checkValue("reset small health_rst", {7'd0, health_rst2}, 8'd1);
        rst_n  = 1'b1;
        rst2_n = 1'b1;
        repeat (3) step();
        checkValue("idle after reset", {4'd0, state_out, health_rst}, 8'd1);

        // ---- table for the one-frame instance ----
        vecs.push_back(mk(0,1,0,0,0, 3'd1,0,0,0,0, 2'd0));
        vecs.push_back(mk(1,0,0,1,0, 3'd1,0,0,0,0, 2'd0));
        vecs.push_back(mk(0,0,0,0,0, 3'd1,0,0,0,0, 2'd0));
        vecs.push_back(mk(0,0,0,0,0, 3'd2,1,0,0,0, 2'd0));
        vecs.push_back(mk(0,0,0,0,1, 3'd3,0,0,1,0, 2'd0));
        vecs.push_back(mk(0,0,0,1,1, 3'd3,0,1,1,0, 2'd0));
        vecs.push_back(mk(0,0,0,0,1, 3'd4,0,0,0,1, 2'd1));
        for (int k = 2; k <= 4; k++) begin
            prev_k = (k - 1 > 3) ? 2'd3 : 2'(k - 1);
            now_k  = (k > 3) ? 2'd3 : 2'(k);
            vecs.push_back(mk(1,0,0,1,0, 3'd4,0,0,0,1, prev_k));
            vecs.push_back(mk(0,0,0,0,0, 3'd4,0,0,0,1, prev_k));
            vecs.push_back(mk(1,0,0,0,0, 3'd1,0,0,0,0, prev_k));
            vecs.push_back(mk(0,0,0,0,0, 3'd1,0,0,0,0, prev_k));
            vecs.push_back(mk(0,0,0,0,0, 3'd2,1,0,0,0, prev_k));
            vecs.push_back(mk(0,0,0,0,0, 3'd3,0,0,1,0, prev_k));
            vecs.push_back(mk(0,0,0,0,1, 3'd3,0,0,1,0, prev_k));
            vecs.push_back(mk(0,0,0,0,1, 3'd4,0,0,0,1, now_k));
        end
        vecs.push_back(mk(0,0,1,0,0, 3'd0,1,0,0,0, 2'd3));
        vecs.push_back(mk(0,1,1,0,0, 3'd0,1,0,0,0, 2'd3));
        vecs.push_back(mk(0,0,0,0,0, 3'd0,1,0,0,0, 2'd3));
        vecs.push_back(mk(0,1,0,0,0, 3'd1,0,0,0,0, 2'd3));
        vecs.push_back(mk(0,1,0,1,0, 3'd1,0,0,0,0, 2'd3));
        vecs.push_back(mk(0,0,1,0,0, 3'd0,1,0,0,0, 2'd3));
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
        end

        // ---- default instance: first spawn ----
        start = 1'b1; step(); start = 1'b0;
        checkValue("start -> spawn_wait", {5'd0, state_out}, 8'd1);
        checkValue("health_rst off in spawn_wait", {7'd0, health_rst}, 8'd0);
        hit_in = 1'b1; #1;
        checkValue("hit gated in spawn_wait", {7'd0, enemy_hit_en}, 8'd0);
        hit_in = 1'b0;
        frameTicks(59);
        checkValue("still waiting after 59 ticks", {5'd0, state_out}, 8'd1);
        waitForState(3'd2, "spawn after 60 ticks", lat);
        checkValue("spawn tick latency", 8'(lat), 8'd3);
        checkValue("spawn health_rst", {6'd0, health_rst, enemy_visible}, 8'd2);
        step();
        checkValue("alive after spawn", {5'd0, state_out}, 8'd3);
        checkValue("alive visible, no health_rst", {6'd0, enemy_visible, health_rst}, 8'd2);
        step();
        hit_in = 1'b1; #1;
        checkValue("hit passes in alive", {7'd0, enemy_hit_en}, 8'd1);
        hit_in = 1'b0; #1;
        checkValue("hit released in alive", {7'd0, enemy_hit_en}, 8'd0);

        // ---- kill, death animation, respawn ----
        enemy_dead = 1'b1; step(); enemy_dead = 1'b0;
        checkValue("kill -> dying", {5'd0, state_out}, 8'd4);
        checkValue("dying outputs", {6'd0, enemy_dying, enemy_visible}, 8'd2);
        checkValue("first kill count", kill_count, 8'd1);
        hit_in = 1'b1; #1;
        checkValue("hit gated in dying", {7'd0, enemy_hit_en}, 8'd0);
        hit_in = 1'b0;
        frameTicks(29);
        checkValue("still dying after 29 ticks", {5'd0, state_out}, 8'd4);
        waitForState(3'd1, "spawn_wait after 30 ticks", lat);
        checkValue("dying tick latency", 8'(lat), 8'd3);
        frameTicks(59);
        checkValue("respawn wait after 59 ticks", {5'd0, state_out}, 8'd1);
        waitForState(3'd2, "respawn after 60 ticks", lat);
        step();
        checkValue("alive again", {5'd0, state_out}, 8'd3);

        // ---- player death during the animation ----
        step();
        enemy_dead = 1'b1; step(); enemy_dead = 1'b0;
        checkValue("second kill count", kill_count, 8'd2);
        frameTicks(19);
        checkValue("dying with timer at 10", {5'd0, state_out}, 8'd4);
        player_dead = 1'b1; step(); player_dead = 1'b0;
        checkValue("player_dead -> idle", {4'd0, state_out, health_rst}, 8'd1);
        checkValue("kills kept on abort", kill_count, 8'd2);
        start = 1'b1; step(); start = 1'b0;
        checkValue("restart -> spawn_wait", {5'd0, state_out}, 8'd1);
        frameTicks(59);
        checkValue("restart waits full delay", {5'd0, state_out}, 8'd1);
        waitForState(3'd2, "restart spawn after 60 ticks", lat);
        step();
        checkValue("alive before async reset", {5'd0, state_out}, 8'd3);

        // ---- asynchronous reset between edges ----
        #2;
        rst_n = 1'b0;
        #1;
        checkValue("async reset state", {5'd0, state_out}, 8'd0);
        checkValue("async reset health_rst/visible", {6'd0, health_rst, enemy_visible}, 8'd2);
        checkValue("async reset kill_count", kill_count, 8'd0);
        step();
        rst_n = 1'b1;
        step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
